stopwatch_time_counter: RTL and testbench

Timekeeping datapath of the stopwatch, directly downstream of the control FSM. A prescaler counts enabled clock cycles and produces one-second increments into a seconds/minutes register pair, with wrap-around at MAX_MIN:59. The FSM's `enable` advances time, and the user reset line drives `clear`. The outputs feed the display stage.

---
 rtl/stopwatch_time_counter_pkg.sv | 18 +
 rtl/stopwatch_time_counter_if.sv | 25 ++
 rtl/stopwatch_time_counter_mod_counter.sv | 35 +++
 rtl/stopwatch_time_counter.sv | 80 ++++++++
 tb/tb_stopwatch_time_counter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/stopwatch_time_counter_pkg.sv
// Shared stopwatch definitions: status encodings, time field limits and widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

  // Control FSM status encodings, shared with the display stage.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } status_e;

  localparam int SEC_MAX         = 59;
  localparam int MAX_MIN_DEFAULT = 99;
  localparam int SEC_W           = 6;
  localparam int MIN_W           = 7;

endpackage

// File: rtl/stopwatch_time_counter_if.sv
// Control-in / time-out bundle between the stopwatch FSM, time counter and display.
// Latency: n/a (wiring only).
// Backpressure: none; the time outputs are free-running registered values.
// master = FSM/display side (drives enable/clear), slave = time counter.
interface stopwatch_time_counter_if;
  import stopwatch_pkg::*;

  logic             enable;
  logic             clear;
  logic [SEC_W-1:0] seconds;
  logic [MIN_W-1:0] minutes;
  logic             sec_tick;
  logic             rollover;

  modport master (
    output enable, clear,
    input  seconds, minutes, sec_tick, rollover
  );

  modport slave (
    input  enable, clear,
    output seconds, minutes, sec_tick, rollover
  );

endinterface

// File: rtl/stopwatch_time_counter_mod_counter.sv
// Modulo-MODULUS up-counter with synchronous clear; wrap flags the last increment.
// Latency: count updates one edge after inc; wrap is combinational from inc/count.
// Backpressure: none; inc is accepted every cycle it is high.
// Ports: clk, rst_n (async active-low), clr (sync, beats inc), inc, count, wrap.
module mod_counter #(
  parameter int MODULUS = 60,
  parameter int W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] r_count;

  // With MODULUS=1 the count is pinned at 0, so every inc is a wrap.
  assign wrap  = inc & (r_count == LAST);
  assign count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timekeeping: prescaler -> seconds -> minutes, wraps MAX_MIN:59 to 00:00.
// Latency: all outputs registered; a second boundary shows one edge after its last enabled cycle.
// Backpressure: none; enable low simply freezes the prescaler and time.
// Ports: clk, rst_n (async active-low), bus (slave: enable/clear in, seconds/minutes/sec_tick/rollover out).
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int MAX_MIN       = MAX_MIN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stopwatch_time_counter_if.slave  bus
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PRE_W-1:0] w_pre_count;
  logic [SEC_W-1:0] w_sec_count;
  logic [MIN_W-1:0] w_min_count;
  logic             w_pre_inc;
  logic             w_pre_wrap;
  logic             w_sec_wrap;
  logic             w_min_wrap;
  logic             w_pre_unused;
  logic             r_sec_tick;
  logic             r_rollover;

  // Clear outranks enable: gating here keeps the whole carry chain quiet
  // in a clear cycle, so no pulse can be generated alongside a clear.
  assign w_pre_inc = bus.enable & ~bus.clear;

  mod_counter #(.MODULUS(TICKS_PER_SEC), .W(PRE_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (w_pre_inc),
    .count (w_pre_count),
    .wrap  (w_pre_wrap)
  );

  mod_counter #(.MODULUS(SEC_MAX + 1), .W(SEC_W)) u_seconds (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (w_pre_wrap),
    .count (w_sec_count),
    .wrap  (w_sec_wrap)
  );

  mod_counter #(.MODULUS(MAX_MIN + 1), .W(MIN_W)) u_minutes (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (w_sec_wrap),
    .count (w_min_count),
    .wrap  (w_min_wrap)
  );

  // The sub-second phase is internal state only; it never leaves the block.
  assign w_pre_unused = ^w_pre_count;

  // Pulses are registered on the same edge that loads the new time,
  // so sec_tick/rollover line up with the updated seconds/minutes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_tick <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_sec_tick <= w_pre_wrap;
      r_rollover <= w_min_wrap;
    end
  end

  assign bus.seconds  = w_sec_count;
  assign bus.minutes  = w_min_count;
  assign bus.sec_tick = r_sec_tick;
  assign bus.rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
module tb_stopwatch_time_counter;
  import stopwatch_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  stopwatch_time_counter_if sw_if ();

  stopwatch_time_counter #(.TICKS_PER_SEC(4), .MAX_MIN(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic clr;
    logic en;
    int   sec;
    int   min;
    logic tick;
    logic roll;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int s, input int m,
                         input logic t, input logic r);
    chk({name, " sec"},  int'(sw_if.seconds),  s);
    chk({name, " min"},  int'(sw_if.minutes),  m);
    chk({name, " tick"}, int'(sw_if.sec_tick), int'(t));
    chk({name, " roll"}, int'(sw_if.rollover), int'(r));
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic c, input logic e);
    sw_if.clear  = c;
    sw_if.enable = e;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  function automatic vec_t mk(input logic c, input logic e, input int s,
                              input int m, input logic t, input logic r);
    vec_t v;
    v.clr = c; v.en = e; v.sec = s; v.min = m; v.tick = t; v.roll = r;
    return v;
  endfunction

  // Watchdog: the run is a few thousand cycles; anything far longer is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    sw_if.clear  = 1'b0;
    sw_if.enable = 1'b0;

    // Continuous run, then pause/resume, then clear-over-enable with a partial second.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));

    // Reset state.
    #12;
    chk_all("reset", 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].en);
      chk_all($sformatf("vec%0d", i), vecs[i].sec, vecs[i].min,
              vecs[i].tick, vecs[i].roll);
    end

    // Async reset mid-count at 01:37: outputs drop before the next edge.
    step(1'b1, 1'b0);
    run(97 * 4 + 2);
    chk_all("pre_reset", 37, 1, 1'b0, 1'b0);
    sw_if.enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Minute carry: 00:59 -> 01:00 without rollover.
    step(1'b1, 1'b0);
    run(59 * 4);
    chk_all("at_00_59", 59, 0, 1'b1, 1'b0);
    run(3);
    chk_all("carry_pre", 59, 0, 1'b0, 1'b0);
    run(1);
    chk_all("carry", 0, 1, 1'b1, 1'b0);

    // Wrap: 02:59 -> 00:00 with a single-cycle rollover.
    run(119 * 4);
    chk_all("at_02_59", 59, 2, 1'b1, 1'b0);
    run(4);
    chk_all("wrap", 0, 0, 1'b1, 1'b1);
    run(1);
    chk_all("wrap_after", 0, 0, 1'b0, 1'b0);

    // Clear with enable at 01:10, prescaler=3: clear wins, phase restarts at 0.
    step(1'b1, 1'b0);
    run(70 * 4 + 3);
    chk_all("at_01_10", 10, 1, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk_all("clr_en", 0, 0, 1'b0, 1'b0);
    run(3);
    chk_all("clr_en_phase", 0, 0, 1'b0, 1'b0);
    run(1);
    chk_all("clr_en_tick", 1, 0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
